// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer
// Per-lane staircase delay stage for the systolic array. SKEW delays lane i by
// i*LANE_STEP enabled cycles to feed operands into the array. DESKEW delays
// lane i by (SA_LENGTH-1-i)*LANE_STEP to realign results leaving it. Every lane
// has at least one register, so lane latency is 1 + delay. Rows carry a valid
// bit and a tile-last flag. Done pulses when the last row of a tile leaves the
// lane with the longest delay.
module systolic_skew_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 256,
    parameter int LANE_STEP  = 1,
    parameter bit ZERO_FILL  = 1'b1
) (
    input  logic                                 CLK,
    input  logic                                 SYNC_RST,
    input  logic                                 EN,
    input  logic                                 Mode,
    input  logic                                 In_Valid,
    input  logic                                 In_Last,
    input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] In_Data,
    output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] Out_Data,
    output logic [SA_LENGTH-1:0]                 Out_Valid,
    output logic                                 Busy,
    output logic                                 Done
);

    // The longest lane delay sets the depth of the shared valid chain.
    localparam int MAX_DELAY = (SA_LENGTH - 1) * LANE_STEP;
    localparam int DEPTH     = MAX_DELAY + 1;

    typedef enum logic {
        MODE_SKEW   = 1'b0,
        MODE_DESKEW = 1'b1
    } mode_e;

    mode_e            mode_q;
    logic [DEPTH-1:0] vld_q;    // stage s holds the row accepted s enabled edges ago
    logic [DEPTH-2:0] lst_q;    // last flags; only needed up to the stage before the final tap
    logic             done_q;
    logic             busy;

    // All lanes accept a row on the same edge, so one valid/last bit per
    // stage serves every lane. Each lane reads this chain at its own tap.
    assign busy = |vld_q;
    assign Busy = busy;
    assign Done = done_q;

    // Valid and last shift chains. They advance only on enabled cycles.
    always_ff @(posedge CLK) begin
        // NOTE: every clocked assignment is non-blocking. Each stage then
        // samples the value its neighbour held before the edge, and the chain
        // shifts by exactly one stage per edge.
        if (SYNC_RST) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (EN) begin
            vld_q    <= {vld_q[DEPTH-2:0], In_Valid};
            lst_q[0] <= In_Valid & In_Last;
            for (int s = 1; s < DEPTH - 1; s++) begin
                lst_q[s] <= lst_q[s-1];
            end
        end
    end

    // Mode register. It loads only when nothing is in flight. The row accepted
    // on that edge sits in stage 0, which the new mode's taps already read.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            mode_q <= MODE_SKEW;
        end else if (EN && !busy) begin
            mode_q <= mode_e'(Mode);
        end
    end

    // Done register. At an enabled edge it captures a last row that is moving
    // into the final stage, so Done rises together with that row's output.
    // A stall edge clears it, so Done is high for one cycle even when the
    // output is frozen.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            done_q <= 1'b0;
        end else begin
            done_q <= EN & vld_q[DEPTH-2] & lst_q[DEPTH-2];
        end
    end

    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
        localparam int SKEW_TAP   = i * LANE_STEP;
        localparam int DESKEW_TAP = (SA_LENGTH - 1 - i) * LANE_STEP;
        // Stages past the deeper of this lane's two taps are never observed,
        // so the lane chain stops at that tap.
        localparam int LANE_DEPTH = ((SKEW_TAP > DESKEW_TAP) ? SKEW_TAP : DESKEW_TAP) + 1;

        logic [LANE_DEPTH-1:0][DATA_WIDTH-1:0] chain_q;
        logic [DATA_WIDTH-1:0]                 in_elem;
        logic [DATA_WIDTH-1:0]                 tap_data;
        logic                                  tap_valid;

        // A bubble enters as zero, so invalid stages never carry stale operands.
        assign in_elem = In_Valid ? In_Data[i] : '0;

        // Per-lane data shift chain.
        always_ff @(posedge CLK) begin
            // NOTE: the data chain is cleared on reset along with the valid
            // bits. Invalid stages then read zero, and no value from before
            // the reset can reach an output.
            if (SYNC_RST) begin
                chain_q <= '0;
            end else if (EN) begin
                chain_q <= {chain_q[LANE_DEPTH-2:0], in_elem};
            end
        end

        // Constant tap indices feed a 2:1 mux. This avoids a variable index
        // into the chain.
        assign tap_valid = (mode_q == MODE_DESKEW) ? vld_q[DESKEW_TAP]   : vld_q[SKEW_TAP];
        assign tap_data  = (mode_q == MODE_DESKEW) ? chain_q[DESKEW_TAP] : chain_q[SKEW_TAP];
        assign Out_Valid[i] = tap_valid;

        if (ZERO_FILL) begin : g_zero
            assign Out_Data[i] = tap_valid ? tap_data : '0;
        end else begin : g_hold
            logic [DATA_WIDTH-1:0] hold_q;

            // Remember the last valid element shown on this lane. Invalid
            // cycles replay it.
            always_ff @(posedge CLK) begin
                if (SYNC_RST) begin
                    hold_q <= '0;
                end else if (EN && tap_valid) begin
                    hold_q <= tap_data;
                end
            end

            assign Out_Data[i] = tap_valid ? tap_data : hold_q;
        end
    end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// tb_systolic_skew_buffer
// Scoreboard bench for systolic_skew_buffer. The stimulus process counts
// enabled edges. For each accepted row it records the enabled-edge number at
// which every lane element is due. A separate negedge monitor presents the
// due elements and compares them with the DUT. A second instance, with
// LANE_STEP=2 and ZERO_FILL=0, is checked against a directed single-row case.
module tb_systolic_skew_buffer;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int D_A = 4;   // 1 + (N-1)*1

    typedef logic [N-1:0][W-1:0] row_t;

    typedef struct {
        int          due;
        logic [W-1:0] data;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic sync_rst, en, mode, in_valid, in_last;
    row_t in_data, out_data;
    logic [N-1:0] out_valid;
    logic busy, done;

    logic b_valid, b_last;
    row_t b_data, b_out_data;
    logic [N-1:0] b_out_valid;
    logic b_busy, b_done;

    systolic_skew_buffer #(.DATA_WIDTH(W), .SA_LENGTH(N), .LANE_STEP(1), .ZERO_FILL(1'b1)) dut_a (
        .CLK(CLK), .SYNC_RST(sync_rst), .EN(en), .Mode(mode),
        .In_Valid(in_valid), .In_Last(in_last), .In_Data(in_data),
        .Out_Data(out_data), .Out_Valid(out_valid), .Busy(busy), .Done(done)
    );

    systolic_skew_buffer #(.DATA_WIDTH(W), .SA_LENGTH(N), .LANE_STEP(2), .ZERO_FILL(1'b0)) dut_b (
        .CLK(CLK), .SYNC_RST(sync_rst), .EN(1'b1), .Mode(1'b0),
        .In_Valid(b_valid), .In_Last(b_last), .In_Data(b_data),
        .Out_Data(b_out_data), .Out_Valid(b_out_valid), .Busy(b_busy), .Done(b_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state. The stimulus process writes it and the monitor reads it.
    int   e_cnt = 0;          // number of enabled, non-reset edges so far
    bit   last_en = 1'b0;     // most recent edge advanced the pipeline
    bit   last_rst = 1'b0;    // most recent edge was a reset
    bit   mon_on = 1'b0;
    int   model_mode = 0;
    bit   have_valid = 1'b0;
    int   last_valid_e = 0;
    exp_t lane_q[N][$];
    int   done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A row accepted at enabled edge k stays in flight while fewer than D_A
    // further enabled edges have passed.
    function automatic bit model_busy();
        return have_valid && ((e_cnt - last_valid_e) <= D_A - 1);
    endfunction

    function automatic int lane_delay(input int m, input int lane);
        return (m != 0) ? (N - 1 - lane) : lane;
    endfunction

    function automatic row_t make_row(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = W'(a);
        r[1] = W'(b);
        r[2] = W'(c);
        r[3] = W'(d);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < N; i++) r[i] = W'($urandom);
        return r;
    endfunction

    // Drive one cycle of stimulus, let the edge happen and update the model.
    // Returns on the following negedge.
    task automatic step(input bit r, input bit e, input bit m, input bit v, input bit l, input row_t d);
        bit busy_before;
        sync_rst = r;
        en       = e;
        mode     = m;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge CLK);
        busy_before = model_busy();
        last_rst = r;
        last_en  = e && !r;
        if (r) begin
            for (int i = 0; i < N; i++) lane_q[i].delete();
            done_q.delete();
            have_valid = 1'b0;
            model_mode = 0;
        end else if (e) begin
            e_cnt++;
            if (!busy_before) model_mode = int'(m);
            if (v) begin
                for (int i = 0; i < N; i++) begin
                    exp_t t;
                    t.due  = e_cnt + lane_delay(model_mode, i);
                    t.data = d[i];
                    lane_q[i].push_back(t);
                end
                if (l) done_q.push_back(e_cnt + D_A - 1);
                have_valid   = 1'b1;
                last_valid_e = e_cnt;
            end
        end
        @(negedge CLK);
    endtask

    task automatic drain(input int n, input bit m);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, m, 1'b0, 1'b0, '0);
    endtask

    // Monitor. It presents due elements at each enabled edge, holds them
    // across stalls and compares the DUT with them every cycle.
    initial begin : monitor
        logic [N-1:0] cur_v;
        row_t         cur_d;
        bit           exp_done;
        exp_t         t;
        cur_v = '0;
        cur_d = '0;
        forever begin
            @(negedge CLK);
            if (mon_on) begin
                exp_done = 1'b0;
                if (last_rst) begin
                    cur_v = '0;
                    cur_d = '0;
                end else if (last_en) begin
                    for (int i = 0; i < N; i++) begin
                        if (lane_q[i].size() > 0 && lane_q[i][0].due == e_cnt) begin
                            t = lane_q[i].pop_front();
                            cur_v[i] = 1'b1;
                            cur_d[i] = t.data;
                        end else begin
                            cur_v[i] = 1'b0;
                            cur_d[i] = '0;
                        end
                    end
                    if (done_q.size() > 0 && done_q[0] == e_cnt) begin
                        exp_done = 1'b1;
                        void'(done_q.pop_front());
                    end
                end
                for (int i = 0; i < N; i++) begin
                    check($sformatf("lane%0d_valid@e%0d", i, e_cnt), 32'(out_valid[i]), 32'(cur_v[i]));
                    check($sformatf("lane%0d_data@e%0d", i, e_cnt), 32'(out_data[i]), 32'(cur_d[i]));
                end
                check($sformatf("busy@e%0d", e_cnt), 32'(busy), 32'(model_busy()));
                check($sformatf("done@e%0d", e_cnt), 32'(done), 32'(exp_done));
            end
        end
    end

    initial begin : stimulus
        row_t exp_row;
        row_t r;
        sync_rst = 1'b1;
        en       = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        b_valid  = 1'b0;
        b_last   = 1'b0;
        b_data   = '0;

        // Reset. The monitor then checks the all-zero idle state.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        mon_on = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // SKEW staircase with two rows. The second row closes the tile.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, make_row(1, 2, 3, 4));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, make_row(5, 6, 7, 8));
        drain(6, 1'b0);

        // DESKEW realign. Lane r carries its real element in row r, so all
        // lanes line up once the fourth row is accepted.
        for (int rr = 0; rr < N; rr++) begin
            r = rand_row();
            r[rr] = W'(-(rr + 1));
            step(1'b0, 1'b1, 1'b1, 1'b1, (rr == N - 1), r);
        end
        for (int i = 0; i < N; i++) exp_row[i] = W'(-(i + 1));
        check("deskew_aligned_valid", 32'(out_valid), 32'hF);
        check("deskew_aligned_data", 32'(out_data), 32'(exp_row));
        drain(6, 1'b1);

        // Stall with EN pattern 1,0,0,1 inside a SKEW tile.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, make_row(1, 2, 3, 4));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, make_row(1, 2, 3, 4));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, make_row(1, 2, 3, 4));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, make_row(5, 6, 7, 8));
        drain(6, 1'b0);

        // Bubble between rows. Mode=1 driven while busy must be ignored until
        // the pipeline empties.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, make_row(11, 12, 13, 14));
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, make_row(99, 99, 99, 99));
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, make_row(15, 16, 17, 18));
        drain(6, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, make_row(-5, -6, -7, -8));
        drain(6, 1'b0);

        // Reset in the middle of a tile. The row driven on the reset edge is discarded.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, make_row(21, 22, 23, 24));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, make_row(25, 26, 27, 28));
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, make_row(29, 30, 31, 32));
        drain(6, 1'b0);

        // Randomised traffic: stalls, bubbles, back-to-back tiles, mode
        // requests and rare resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0), rand_row());
        end
        drain(8, 1'b0);

        // LANE_STEP=2, ZERO_FILL=0 instance: a single row {9,9,9,9} that also closes the tile.
        b_valid = 1'b1;
        b_last  = 1'b1;
        b_data  = make_row(9, 9, 9, 9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        b_valid = 1'b0;
        b_last  = 1'b0;
        b_data  = '0;
        for (int c = 1; c <= 9; c++) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("b_lane%0d_valid@c%0d", i, c), 32'(b_out_valid[i]), 32'(c == 1 + 2 * i));
                check($sformatf("b_lane%0d_data@c%0d", i, c), 32'(b_out_data[i]), (c >= 1 + 2 * i) ? 32'd9 : 32'd0);
            end
            check($sformatf("b_done@c%0d", c), 32'(b_done), 32'(c == 7));
            check($sformatf("b_busy@c%0d", c), 32'(b_busy), 32'(c <= 7));
            if (c < 9) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end

        // Every expected element and Done pulse must have been presented.
        for (int i = 0; i < N; i++) begin
            check($sformatf("lane%0d_pending", i), 32'(lane_q[i].size()), 32'd0);
        end
        check("done_pending", 32'(done_q.size()), 32'd0);

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
